mtsp_bus_responder: RTL and testbench
=====================================

// Module: mtsp_bus_responder
// PURPOSE
//  Far end of the MTSP memory-command interface: pops descriptors from the Meitner bus command FIFO, executes them on a
//  single-port SRAM-style external memory, returns read data to the register write-back path.
//  One transaction in flight; the pop strobe (mem_command_valid) doubles as the completion/thread-awake strobe.
// PARAMETERS
//  ADDR_W          14    word address width (desc[141:128])
//  DATA_W          128   data width, DWORDx4 (desc[127:0])
//  TIMEOUT_CYCLES  256   read-response timeout, MTSP_BUS_RESP_TIMEOUT_EN only
// PORTS
//  CLK                 in   1        main clock
//  nRST                in   1        reset, asynchronous, active low
//  mem_command_en      in   1        FIFO not empty; descriptor valid
//  mem_command_desc    in   144      {rsvd[143], WRITE[142], ADDR[141:128], DATA[127:0]}
//  mem_command_valid   out  1        completion pulse; pops FIFO, awakes thread
//  MEM_REQ             out  1        external access request
//  MEM_WE              out  1        1=write, 0=read
//  MEM_ADDR            out  ADDR_W   word address
//  MEM_WDATA           out  DATA_W   write data
//  MEM_GNT             in   1        request accepted this cycle
//  MEM_RVALID          in   1        read data valid
//  MEM_RDATA           in   DATA_W   read data
//  RD_VALID            out  1        read result available to write-back
//  RD_DATA             out  DATA_W   read result (registered)
//  RD_READY            in   1        write-back accepts result
//  RESP_ERR            out  1        sticky timeout flag (0 when macro off)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; RD_DATA 0; timer 0. Async reset mid-transaction aborts it silently, no pop.
//  FSM IDLE -> ISSUE -> (write) IDLE | (read) WAIT_RD -> RESP -> IDLE.
//  IDLE: mem_command_en=1 -> ISSUE next cycle. rsvd bit ignored.
//  ISSUE: MEM_REQ=1; MEM_WE/ADDR/WDATA driven combinationally from desc (desc stable until pop).
//   Write + MEM_GNT: mem_command_valid=1 same cycle -> IDLE. Write latency en->pop = 2 cycles minimum.
//   Read + MEM_GNT -> WAIT_RD. No GNT: hold REQ and fields unchanged.
//  WAIT_RD: MEM_RVALID captured into RD_DATA -> RESP. MEM_RVALID in any other state ignored.
//   Data arrives at earliest the cycle after GNT.
//  RESP: RD_VALID=1, RD_DATA held. RD_READY=1 -> mem_command_valid=1 same cycle -> IDLE.
//   Read result and pop are simultaneous by construction.
//  mem_command_valid is never asserted unless mem_command_en=1. Exactly one pulse per descriptor.
//  Back-to-back: a new command is not sampled in the completion cycle; FIFO output updates next cycle.
//   Next ISSUE starts >=1 cycle after pop (IDLE cycle sees new en).
//  RD_READY while RD_VALID=0: no effect. MEM_GNT outside ISSUE: ignored.
// CONFIGURATION
//  MTSP_BUS_RESP_TIMEOUT_EN defined:
//   - Counter runs in WAIT_RD, cleared on entry.
//   - Reaching TIMEOUT_CYCLES-1 without MEM_RVALID -> RD_DATA=0, RESP_ERR set (sticky until reset), -> RESP.
//   - A late MEM_RVALID is then ignored.
//  Undefined: no counter; WAIT_RD waits indefinitely; RESP_ERR tied 0.
// STRUCTURE
//  Package mtsp_bus_pkg:
//   - mem_desc_t packed struct (rsvd, write, addr, data).
//   - resp_state_t enum {IDLE, ISSUE, WAIT_RD, RESP}.
//   - Constants MEM_DESC_W=144 and TIMEOUT_CYCLES default.
//  Sub-module: mtsp_bus_resp_timer (timeout counter, clear/enable/expire), instantiated only under the macro.
// TESTING
//  1. Write A=0x0123 D=0xDEADBEEF.., GNT same cycle as REQ -> MEM_WE=1, one pop 2 cycles after en; no RD_VALID.
//  2. Read A=0x3FFF, GNT delayed 3 cycles, RVALID 2 cycles later with 0xCAFE.. -> REQ held 4 cycles; RD_DATA=0xCAFE..;
//     pop coincident with RD_READY.
//  3. RD_READY low 5 cycles in RESP -> RD_VALID/RD_DATA stable, no pop until READY; then single pop.
//  4. FIFO preloaded with 4 mixed cmds, GNT/RVALID/READY tied 1 -> 4 pops in order, addresses match, 1 IDLE cycle between.
//  5. nRST asserted in WAIT_RD -> all outputs 0 immediately; no pop; after release same FIFO head re-executed.
//  6. Macro on, TIMEOUT_CYCLES=8, no RVALID -> RD_VALID with RD_DATA=0 after 8 cycles, RESP_ERR=1 sticky;
//     late RVALID ignored.

Source files
------------

// File: rtl/mtsp_bus_pkg.sv
// Shared types and constants for the MTSP bus responder: command descriptor layout,
// responder FSM states and default sizes.
package mtsp_bus_pkg;

    localparam int MEM_DESC_W             = 144;
    localparam int DESC_ADDR_W            = 14;
    localparam int DESC_DATA_W            = 128;
    localparam int TIMEOUT_CYCLES_DEFAULT = 256;

    typedef struct packed {
        logic                   rsvd;
        logic                   write;
        logic [DESC_ADDR_W-1:0] addr;
        logic [DESC_DATA_W-1:0] data;
    } mem_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } resp_state_t;

endpackage

// File: rtl/mtsp_bus_resp_timer.sv
// Read-response watchdog: counts cycles while enabled, restarts when cleared and
// flags expiry on the last allowed cycle.
module mtsp_bus_resp_timer #(
    parameter int CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] count;

    assign expire = enable && (count == CNT_W'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mtsp_bus_responder.sv
// Executes MTSP memory-command descriptors one at a time on a single-port external memory.
// Optional read-response timeout is enabled by defining MTSP_BUS_RESP_TIMEOUT_EN.
module mtsp_bus_responder
    import mtsp_bus_pkg::*;
#(
    parameter int ADDR_W         = DESC_ADDR_W,
    parameter int DATA_W         = DESC_DATA_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  mem_command_en,
    input  logic [MEM_DESC_W-1:0] mem_command_desc,
    output logic                  mem_command_valid,
    output logic                  MEM_REQ,
    output logic                  MEM_WE,
    output logic [ADDR_W-1:0]     MEM_ADDR,
    output logic [DATA_W-1:0]     MEM_WDATA,
    input  logic                  MEM_GNT,
    input  logic                  MEM_RVALID,
    input  logic [DATA_W-1:0]     MEM_RDATA,
    output logic                  RD_VALID,
    output logic [DATA_W-1:0]     RD_DATA,
    input  logic                  RD_READY,
    output logic                  RESP_ERR
);

    mem_desc_t   desc;
    resp_state_t state;
    resp_state_t state_next;
    logic        rd_capture;
    logic        rd_timeout;
    logic        rd_expire;
    logic        unused_rsvd;

    assign desc        = mem_desc_t'(mem_command_desc);
    assign unused_rsvd = desc.rsvd;
    assign RD_VALID    = (state == RESP);

`ifdef MTSP_BUS_RESP_TIMEOUT_EN
    logic resp_err;

    mtsp_bus_resp_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (nRST),
        .clear  (state != WAIT_RD),
        .enable (state == WAIT_RD),
        .expire (rd_expire)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            resp_err <= 1'b0;
        end else if (rd_timeout) begin
            resp_err <= 1'b1;
        end
    end

    assign RESP_ERR = resp_err;
`else
    logic [31:0] unused_timeout;

    assign unused_timeout = TIMEOUT_CYCLES;
    assign rd_expire      = 1'b0;
    assign RESP_ERR       = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next        = state;
        MEM_REQ           = 1'b0;
        MEM_WE            = 1'b0;
        MEM_ADDR          = '0;
        MEM_WDATA         = '0;
        mem_command_valid = 1'b0;
        rd_capture        = 1'b0;
        rd_timeout        = 1'b0;
        case (state)
            IDLE: begin
                if (mem_command_en) state_next = ISSUE;
            end
            ISSUE: begin
                MEM_REQ   = 1'b1;
                MEM_WE    = desc.write;
                MEM_ADDR  = ADDR_W'(desc.addr);
                MEM_WDATA = DATA_W'(desc.data);
                if (MEM_GNT) begin
                    if (desc.write) begin
                        mem_command_valid = mem_command_en;
                        state_next        = IDLE;
                    end else begin
                        state_next = WAIT_RD;
                    end
                end
            end
            WAIT_RD: begin
                // Real data wins over an expiry landing in the same cycle.
                if (MEM_RVALID) begin
                    rd_capture = 1'b1;
                    state_next = RESP;
                end else if (rd_expire) begin
                    rd_timeout = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (RD_READY) begin
                    mem_command_valid = mem_command_en;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state and data registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            RD_DATA <= '0;
        end else begin
            state <= state_next;
            if (rd_capture) begin
                RD_DATA <= MEM_RDATA;
            end else if (rd_timeout) begin
                RD_DATA <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mtsp_bus_responder.sv
// Randomized scoreboard bench for mtsp_bus_responder: FIFO + memory models on the bus side,
// reference memory predicts every completion. Timeout scenario runs when MTSP_BUS_RESP_TIMEOUT_EN is defined.
module tb_mtsp_bus_responder;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         mem_command_en;
    logic [143:0] mem_command_desc;
    logic         mem_command_valid;
    logic         MEM_REQ;
    logic         MEM_WE;
    logic [13:0]  MEM_ADDR;
    logic [127:0] MEM_WDATA;
    logic         MEM_GNT;
    logic         MEM_RVALID;
    logic [127:0] MEM_RDATA;
    logic         RD_VALID;
    logic [127:0] RD_DATA;
    logic         RD_READY;
    logic         RESP_ERR;

    mtsp_bus_responder #(
        .ADDR_W         (14),
        .DATA_W         (128),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .mem_command_en    (mem_command_en),
        .mem_command_desc  (mem_command_desc),
        .mem_command_valid (mem_command_valid),
        .MEM_REQ           (MEM_REQ),
        .MEM_WE            (MEM_WE),
        .MEM_ADDR          (MEM_ADDR),
        .MEM_WDATA         (MEM_WDATA),
        .MEM_GNT           (MEM_GNT),
        .MEM_RVALID        (MEM_RVALID),
        .MEM_RDATA         (MEM_RDATA),
        .RD_VALID          (RD_VALID),
        .RD_DATA           (RD_DATA),
        .RD_READY          (RD_READY),
        .RESP_ERR          (RESP_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit           wr;
        logic [13:0]  addr;
        logic [127:0] data;
        int           lat;
        int           rlen;
    } exp_t;

    exp_t         exp_q[$];
    logic [143:0] fifo[$];
    logic [127:0] sim_mem[logic [13:0]];
    logic [127:0] ref_mem[logic [13:0]];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int head_cyc    = 0;
    bit head_new    = 0;

    bit tied        = 0;
    int gnt_delay   = -1;
    int rv_fixed    = -1;
    bit ready_mode  = 0;
    int ready_block = 0;
    bit rd_pending  = 0;
    int req_cnt     = 0;
    int last_req_len = 0;
    bit exp_err     = 0;

    logic [13:0] addr_pool [8] = '{14'h0000, 14'h0001, 14'h0123, 14'h0400,
                                   14'h1555, 14'h2AAA, 14'h3FFE, 14'h3FFF};

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    function automatic logic [127:0] init_val(input logic [13:0] a);
        logic [31:0] w;
        w = 32'h5A5A0000 | {18'h0, a};
        return {4{w}};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference model: in-order execution, so a read returns the latest earlier write.
    task automatic push_cmd(input bit wr, input logic [13:0] a, input logic [127:0] d,
                            input bit timeout, input int lat, input int rlen);
        exp_t e;
        e.wr   = wr;
        e.addr = a;
        e.lat  = lat;
        e.rlen = rlen;
        if (wr) begin
            e.data     = d;
            ref_mem[a] = d;
        end else if (timeout) begin
            e.data = '0;
        end else begin
            e.data = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        end
        exp_q.push_back(e);
        fifo.push_back({1'($urandom_range(0, 1)), wr, a, d});
    endtask

    task automatic set_mode(input bit t, input int gd, input int rv, input bit rm);
        tied       = t;
        gnt_delay  = gd;
        rv_fixed   = rv;
        ready_mode = rm;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((fifo.size() != 0 || exp_q.size() != 0) && n < limit) begin
            @(negedge CLK);
            n++;
        end
        if (n >= limit) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d commands still pending after %0d cycles", exp_q.size(), limit);
            finish_run();
        end
        repeat (2) @(negedge CLK);
    endtask

    // Bus side: presents the command FIFO and plays the external memory.
    initial begin : driver
        bit           popped;
        int           rd_wait;
        logic [127:0] rd_val;
        popped           = 0;
        rd_wait          = 0;
        rd_val           = '0;
        mem_command_en   = 0;
        mem_command_desc = '0;
        MEM_GNT          = 0;
        MEM_RVALID       = 0;
        MEM_RDATA        = '0;
        RD_READY         = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (popped) begin
                fifo.delete(0);
                popped   = 0;
                head_new = 1;
            end
            if (fifo.size() != 0) begin
                if (!mem_command_en || head_new) head_cyc = cyc;
                mem_command_en   = 1;
                mem_command_desc = fifo[0];
            end else begin
                mem_command_en   = 0;
                mem_command_desc = '0;
            end
            head_new = 0;

            @(negedge CLK);
            if (!nRST) begin
                MEM_GNT    = 0;
                MEM_RVALID = 0;
                RD_READY   = 0;
                rd_pending = 0;
                req_cnt    = 0;
                continue;
            end
            if (rd_pending) begin
                rd_wait--;
                MEM_RVALID = (rd_wait == 0);
                MEM_RDATA  = (rd_wait == 0) ? rd_val : rand128();
                if (rd_wait == 0) rd_pending = 0;
            end else begin
                MEM_RVALID = tied || ($urandom_range(0, 7) == 0);
                MEM_RDATA  = rand128();
            end
            req_cnt = MEM_REQ ? req_cnt + 1 : 0;
            if (tied)
                MEM_GNT = 1;
            else if (gnt_delay >= 0)
                MEM_GNT = MEM_REQ && (req_cnt > gnt_delay);
            else
                MEM_GNT = MEM_REQ ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) == 0);
            if (MEM_REQ && MEM_GNT) begin
                last_req_len = req_cnt;
                if (MEM_WE) begin
                    sim_mem[MEM_ADDR] = MEM_WDATA;
                end else begin
                    rd_pending = 1;
                    rd_val     = sim_mem.exists(MEM_ADDR) ? sim_mem[MEM_ADDR] : init_val(MEM_ADDR);
                    rd_wait    = tied ? 1 : (rv_fixed >= 0 ? rv_fixed : int'($urandom_range(1, 5)));
                end
            end
            if (tied) begin
                RD_READY = 1;
            end else if (RD_VALID && ready_block > 0) begin
                RD_READY = 0;
                ready_block--;
            end else if (ready_mode) begin
                RD_READY = 1;
            end else begin
                RD_READY = ($urandom_range(0, 1) == 1);
            end
            #1 popped = mem_command_valid;
        end
    end

    // Scoreboard: every completion pulse retires the oldest expected command.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (nRST && mem_command_valid) begin
                check("expected_queue_nonempty", exp_q.size() != 0, 1);
                check("pop_with_en", mem_command_en, 1);
                check("resp_err", RESP_ERR, exp_err);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (e.wr) begin
                        check("wr_we", MEM_WE, 1);
                        check("wr_addr", MEM_ADDR, e.addr);
                        check("wr_data", MEM_WDATA, e.data);
                        check("wr_no_rd_valid", RD_VALID, 0);
                    end else begin
                        check("rd_valid_at_pop", RD_VALID, 1);
                        check("rd_data", RD_DATA, e.data);
                        check("rd_no_req", MEM_REQ, 0);
                    end
                    if (e.lat >= 0) check("latency", cyc + 1 - head_cyc, e.lat);
                    if (e.rlen >= 0) check("req_len", last_req_len, e.rlen);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [127:0] held;
        logic [13:0]  a;
        int           n;
        nRST = 0;
        repeat (3) @(negedge CLK);
        #1;
        check("rst_ctrl", {MEM_REQ, MEM_WE, RD_VALID, mem_command_valid, RESP_ERR}, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_wdata", MEM_WDATA, 0);
        check("rst_rd_data", RD_DATA, 0);
        #2 nRST = 1;
        repeat (2) @(negedge CLK);

        // Write, immediate grant: pop two edges after en, single REQ cycle.
        set_mode(0, 0, -1, 1);
        push_cmd(1, 14'h0123, {4{32'hDEADBEEF}}, 0, 2, 1);
        drain(100);

        // Read with grant delayed 3 cycles and data 2 cycles after grant.
        sim_mem[14'h3FFF] = {4{32'hCAFEF00D}};
        ref_mem[14'h3FFF] = {4{32'hCAFEF00D}};
        set_mode(0, 3, 2, 1);
        push_cmd(0, 14'h3FFF, '0, 0, 8, 4);
        drain(100);

        // Write-back stalls for 5 cycles: result must stay put and nothing pops.
        set_mode(0, -1, -1, 1);
        ready_block = 5;
        push_cmd(0, 14'h0123, '0, 0, -1, -1);
        n = 0;
        do begin
            @(negedge CLK);
            #3;
            n++;
        end while (!RD_VALID && n < 100);
        check("stall_reached_resp", RD_VALID, 1);
        held = RD_DATA;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge CLK);
                #3;
            end
            check("stall_valid", RD_VALID, 1);
            check("stall_data", RD_DATA, held);
            check("stall_no_pop", mem_command_valid, 0);
        end
        drain(100);

        // Preloaded FIFO with all handshakes tied high: fixed cadence, one IDLE between commands.
        set_mode(1, -1, -1, 1);
        a = 14'h0010;
        push_cmd(1, a, rand128(), 0, 2, 1);
        push_cmd(0, a, '0, 0, 4, 1);
        push_cmd(1, 14'h2222, rand128(), 0, 2, 1);
        push_cmd(0, 14'h3FFF, '0, 0, 4, 1);
        drain(200);

        // Reset in WAIT_RD: outputs clear at once, no pop, head re-executes afterwards.
        set_mode(0, 0, 40, 0);
        push_cmd(0, 14'h0123, '0, 0, -1, -1);
        n = 0;
        while (!rd_pending && n < 50) begin
            @(negedge CLK);
            #3;
            n++;
        end
        check("reset_reached_wait", rd_pending, 1);
        repeat (2) @(negedge CLK);
        #3 nRST = 0;
        #1;
        check("abort_ctrl", {MEM_REQ, MEM_WE, RD_VALID, mem_command_valid, RESP_ERR}, 0);
        check("abort_addr", MEM_ADDR, 0);
        check("abort_rd_data", RD_DATA, 0);
        rv_fixed = -1;
        repeat (2) @(negedge CLK);
        #3 nRST = 1;
        drain(300);

        // Randomized traffic over a small address pool so reads hit earlier writes.
        set_mode(0, -1, -1, 0);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge CLK);
            a = addr_pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 1)
                push_cmd(1, a, rand128(), 0, -1, -1);
            else
                push_cmd(0, a, '0, 0, -1, -1);
        end
        drain(3000);

`ifdef MTSP_BUS_RESP_TIMEOUT_EN
        // No data within 8 WAIT_RD cycles: zero result, sticky error, late data ignored.
        set_mode(0, 0, 12, 1);
        ready_block = 6;
        exp_err     = 1;
        push_cmd(0, 14'h0123, '0, 1, 17, 1);
        drain(200);
        set_mode(0, -1, -1, 0);
        for (int i = 0; i < 6; i++) begin
            a = addr_pool[$urandom_range(0, 7)];
            push_cmd(i % 2 == 0, a, rand128(), 0, -1, -1);
        end
        drain(500);
`endif

        finish_run();
    end

endmodule
